icache_refill_unit: RTL and testbench
=====================================

Name: icache_refill_unit

Overview:
- Miss-service engine that feeds the instruction cache's fill bus.
- Watches the cache miss flag and fetch PC, and arbitrates for the shared byte-wide RAM port.
- Reads the 4 bytes of the missing word, assembles them little-endian, then pulses one fill write (ram_bus_en/pc/inst) into the cache.
- Sits between the instruction cache and the memory arbiter, alongside the fetch stage.

Parameters:
- ADDR_W, 32, address width of the PC and the RAM address.
- INST_W, 32, instruction width. Fixed at 4 bytes; other values are unsupported.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when 0, all state freezes.
- flush_in  input  1  fetch redirect (mispredict/jump); aborts an outstanding refill.
- miss_in  input  1  cache miss flag for miss_pc_in, level-sensitive.
- miss_pc_in  input  ADDR_W  PC currently missing in the cache.
- mem_req_out  output  1  request for the shared RAM port.
- mem_gnt_in  input  1  arbiter grant, held high while mem_req_out stays high.
- mem_a_out  output  ADDR_W  RAM byte address.
- mem_din_in  input  8  RAM read data; valid one cycle after its address is presented.
- ram_bus_en_out  output  1  one-cycle fill strobe to the cache.
- ram_bus_pc_out  output  ADDR_W  PC of the filled word.
- ram_bus_inst_out  output  INST_W  filled instruction word.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE, cnt=0, and every output is 0. Reset mid-refill abandons the refill; no fill is emitted.
- rdy_in=0: no state, counter, or output register changes. The memory side stalls under the same rdy_in, so the data alignment is preserved.
- Base address: base = {miss_pc_in[ADDR_W-1:2], 2'b00}, latched as lpc on leaving IDLE.
- IDLE:
  - If miss_in=1, flush_in=0, and ram_bus_en_out was 0 last cycle: latch lpc, go to REQ.
  - The fill-cycle guard prevents a second request while the cache is still updating.
- REQ:
  - mem_req_out=1.
  - On mem_gnt_in=1, drive mem_a_out=lpc+0, set cnt=1, go to READ.
- READ (mem_req_out=1; cnt counts issued addresses):
  - While cnt<4: mem_a_out=lpc+cnt, and cnt increments.
  - The byte arriving each cycle goes into buf[8*(k)+:8], where k is the byte index issued the previous cycle.
  - After the 4th byte (lpc+3) is captured: go to DONE, mem_req_out=0.
  - Timing: grant cycle G issues byte 0. Bytes 0..3 are captured at G+1..G+4. DONE is entered at G+5.
- DONE:
  - ram_bus_en_out=1 for exactly one cycle, with ram_bus_pc_out=lpc and ram_bus_inst_out=buf.
  - Next state is IDLE. ram_bus_en_out returns to 0; pc/inst hold their values.
- flush_in=1 in any state: go to IDLE next cycle, mem_req_out=0, no fill.
  - Flush in the same cycle as DONE suppresses ram_bus_en_out.
  - Flush takes priority over a simultaneous miss/grant.
- miss_in dropping or miss_pc_in changing during REQ/READ is ignored. The refill completes with the latched lpc.
- Address arithmetic is modulo 2^ADDR_W. lpc=0xFFFFFFFC reads 0xFFFFFFFC..0xFFFFFFFF with no wrap into the next word.
- mem_gnt_in dropping during READ is a protocol violation; the bench asserts it never occurs.
- At most one refill is in flight; there is no prefetch.

Test Plan:
- Basic refill:
  - Stimulus: miss_in=1, miss_pc_in=0x00001006. Grant at cycle 2. RAM bytes at 0x1004..0x1007 = 13,05,00,00.
  - Required: mem_a_out = 0x1004, 0x1005, 0x1006, 0x1007 on consecutive cycles. A single ram_bus_en_out pulse at grant+5 with pc=0x1004, inst=0x00000513. mem_req_out=0 afterwards.
- Grant delay:
  - Stimulus: grant withheld for 7 cycles.
  - Required: mem_req_out held at 1 and mem_a_out does not advance. Fill arrives exactly grant+5.
- Flush mid-READ:
  - Stimulus: flush_in=1 after byte 1 is captured.
  - Required: next cycle state=IDLE, mem_req_out=0, and no ram_bus_en_out pulse. A new miss at 0x2000 then refills correctly.
- Flush coincident with DONE:
  - Required: ram_bus_en_out stays 0.
- rdy_in low for 3 cycles mid-READ:
  - Required: mem_a_out and cnt frozen. The assembled word is still correct and the fill is delayed by exactly 3 cycles.
- Async reset during READ, and back-to-back misses:
  - Reset during READ: all outputs read 0 immediately, without waiting for a clock edge.
  - Back-to-back misses 0x0 then 0x4, with miss_in held high through the fill cycle: exactly two fills, and no duplicate request for 0x0.

Source files
------------

// File: rtl/icache_refill_unit_if.sv
// icache_refill_unit_if: shared RAM read port plus the instruction-cache fill bus
interface icache_refill_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              mem_req_out;
    logic              mem_gnt_in;
    logic [ADDR_W-1:0] mem_a_out;
    logic [7:0]        mem_din_in;
    logic              ram_bus_en_out;
    logic [ADDR_W-1:0] ram_bus_pc_out;
    logic [INST_W-1:0] ram_bus_inst_out;

    modport master (
        output mem_req_out, mem_a_out, ram_bus_en_out, ram_bus_pc_out, ram_bus_inst_out,
        input  mem_gnt_in, mem_din_in
    );

    modport slave (
        input  mem_req_out, mem_a_out, ram_bus_en_out, ram_bus_pc_out, ram_bus_inst_out,
        output mem_gnt_in, mem_din_in
    );
endinterface

// File: rtl/icache_refill_unit.sv
// icache_refill_unit: reads the 4 bytes of a missing word and pulses one cache fill
module icache_refill_unit #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 miss_in,
    input  logic [ADDR_W-1:0]    miss_pc_in,
    icache_refill_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, READ, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] lpc;
    logic [INST_W-1:0] line_buf;
    logic              fill_q;
    logic [1:0]        k;

    // byte lane of the data arriving now: the index issued one cycle earlier
    assign k = cnt[1:0] - 2'd1;
    assign bus.ram_bus_pc_out = lpc;
    assign bus.ram_bus_inst_out = line_buf;

    // state register, frozen while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) state <= IDLE;
        else if (rdy_in) state <= state_nxt;

    // next state, counter and bus outputs; flush overrides everything
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        bus.mem_req_out = 1'b0;
        bus.mem_a_out = '0;
        bus.ram_bus_en_out = 1'b0;
        case (state)
            IDLE: if (miss_in && !fill_q) state_nxt = REQ;
            REQ: begin
                bus.mem_req_out = 1'b1;
                bus.mem_a_out = lpc;
                if (bus.mem_gnt_in) begin
                    state_nxt = READ;
                    cnt_nxt = 3'd1;
                end
            end
            READ: begin
                bus.mem_req_out = 1'b1;
                bus.mem_a_out = lpc + ADDR_W'(cnt[2] ? 3'd3 : cnt);
                if (cnt[2]) state_nxt = DONE;
                else cnt_nxt = cnt + 3'd1;
            end
            DONE: begin
                bus.ram_bus_en_out = 1'b1;
                state_nxt = IDLE;
                cnt_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_in) begin
            state_nxt = IDLE;
            cnt_nxt = '0;
            bus.ram_bus_en_out = 1'b0;
        end
    end

    // counter, latched word address, little-endian assembly, last-cycle fill flag
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            cnt <= '0;
            lpc <= '0;
            line_buf <= '0;
            fill_q <= 1'b0;
        end else if (rdy_in) begin
            cnt <= cnt_nxt;
            fill_q <= bus.ram_bus_en_out;
            if (state == IDLE && state_nxt == REQ) lpc <= miss_pc_in & ~ADDR_W'(3);
            if (state == READ && !flush_in) line_buf[{k, 3'b000} +: 8] <= bus.mem_din_in;
        end
endmodule

// File: tb/tb_icache_refill_unit.sv
// tb_icache_refill_unit: directed vectors and corner sequences for the refill engine
module tb_icache_refill_unit;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        miss_in = 1'b0;
    logic [31:0] miss_pc_in = '0;
    int          checks = 0;
    int          errors = 0;
    int          fills = 0;

    typedef struct {
        logic [31:0] pc;
        int          gdel;
        bit          drop;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t vecs [4];

    icache_refill_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

    icache_refill_unit #(.ADDR_W(32), .INST_W(32)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .flush_in(flush_in),
        .miss_in(miss_in),
        .miss_pc_in(miss_pc_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h1004: return 8'h13;
            32'h1005: return 8'h05;
            32'h1006, 32'h1007: return 8'h00;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM: data valid one cycle after the address, stalled by the same rdy_in
    always @(posedge clk_in) if (rdy_in) bus.mem_din_in <= mem_byte(bus.mem_a_out);

    // count fill strobes, sampled just after the falling edge
    always @(negedge clk_in) begin
        #1;
        if (bus.ram_bus_en_out) fills++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // mode: 0 normal, 1 flush in DONE, 2 flush after byte 1, 3 rdy low 3 cycles,
    //       4 async reset mid-READ, 5 keep miss high through the fill cycle
    task automatic run_refill(input logic [31:0] pc, input int gdel, input bit drop,
                              input logic [31:0] epc, input logic [31:0] einst, input int mode);
        int  off;
        int  k;
        int  nf;
        bit  seen;
        off = (mode == 3) ? 3 : 0;
        nf = fills;
        @(negedge clk_in);
        miss_in = 1'b1;
        miss_pc_in = pc;
        bus.mem_gnt_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk_in);
            #1;
            seen = bus.mem_req_out;
        end
        chk("req_rise", {31'b0, seen}, 1);
        for (int i = 0; i < gdel; i++) begin
            @(negedge clk_in);
            #1;
            chk("stall_req", {31'b0, bus.mem_req_out}, 1);
            chk("stall_addr", bus.mem_a_out, epc);
        end
        @(negedge clk_in);
        bus.mem_gnt_in = 1'b1;
        if (drop) begin
            miss_in = 1'b0;
            miss_pc_in = 32'hDEAD_BEEF;
        end
        #1;
        chk("addr0", bus.mem_a_out, epc);
        for (int c = 1; c <= 6 + off; c++) begin
            @(negedge clk_in);
            if (mode == 3) rdy_in = !(c >= 2 && c <= 4);
            flush_in = (mode == 1 && c == 5 + off) || (mode == 2 && c == 3);
            if (mode == 2 && c == 3) miss_in = 1'b0;
            if ((mode == 2 && c == 4) || c == 5 + off) bus.mem_gnt_in = 1'b0;
            if (c == 5 + off && mode != 5) miss_in = 1'b0;
            #1;
            if (mode == 2 && c == 4) begin
                chk("flush_req", {31'b0, bus.mem_req_out}, 0);
                chk("flush_en", {31'b0, bus.ram_bus_en_out}, 0);
                break;
            end
            k = (mode == 3 && c >= 3) ? ((c <= 5) ? 2 : c - 3) : c;
            if (k <= 3 && c <= 3 + off) chk("addr", bus.mem_a_out, epc + k);
            if (c == 4 + off) chk("pre_en", {31'b0, bus.ram_bus_en_out}, 0);
            if (c == 5 + off) begin
                chk("fill_en", {31'b0, bus.ram_bus_en_out}, (mode != 1) ? 1 : 0);
                if (mode != 1) begin
                    chk("fill_pc", bus.ram_bus_pc_out, epc);
                    chk("fill_inst", bus.ram_bus_inst_out, einst);
                end
            end
            if (c == 6 + off) begin
                chk("post_en", {31'b0, bus.ram_bus_en_out}, 0);
                chk("post_req", {31'b0, bus.mem_req_out}, 0);
            end
            if (mode == 4 && c == 2) begin
                #2;
                rst_in = 1'b0;
                #1;
                chk("rst_req", {31'b0, bus.mem_req_out}, 0);
                chk("rst_addr", bus.mem_a_out, 0);
                chk("rst_en", {31'b0, bus.ram_bus_en_out}, 0);
                chk("rst_pc", bus.ram_bus_pc_out, 0);
                chk("rst_inst", bus.ram_bus_inst_out, 0);
                miss_in = 1'b0;
                bus.mem_gnt_in = 1'b0;
                @(negedge clk_in);
                rst_in = 1'b1;
                break;
            end
        end
        if (mode == 1 || mode == 2 || mode == 4) begin
            repeat (8) @(negedge clk_in);
            #2;
            chk("no_fill", fills - nf, 0);
        end else begin
            #1;
            chk("one_fill", fills - nf, 1);
        end
    endtask

    initial begin
        int nf;
        vecs[0] = '{32'h0000_1006, 2, 1'b0, 32'h0000_1004, 32'h0000_0513};
        vecs[1] = '{32'h0000_0123, 7, 1'b0, 32'h0000_0120, 32'h7978_7B7A};
        vecs[2] = '{32'hFFFF_FFFE, 0, 1'b1, 32'hFFFF_FFFC, 32'hA5A4_A7A6};
        vecs[3] = '{32'h0000_2000, 1, 1'b0, 32'h0000_2000, 32'h5958_5B5A};
        bus.mem_gnt_in = 1'b0;
        #1;
        rst_in = 1'b0;
        #11;
        chk("reset_req", {31'b0, bus.mem_req_out}, 0);
        chk("reset_addr", bus.mem_a_out, 0);
        chk("reset_en", {31'b0, bus.ram_bus_en_out}, 0);
        chk("reset_pc", bus.ram_bus_pc_out, 0);
        chk("reset_inst", bus.ram_bus_inst_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            run_refill(vecs[i].pc, vecs[i].gdel, vecs[i].drop, vecs[i].epc, vecs[i].einst, 0);
            repeat (2) @(negedge clk_in);
        end
        @(negedge clk_in);
        miss_in = 1'b1;
        miss_pc_in = 32'h0000_6000;
        flush_in = 1'b1;
        @(negedge clk_in);
        miss_in = 1'b0;
        flush_in = 1'b0;
        #1;
        chk("flush_prio", {31'b0, bus.mem_req_out}, 0);
        repeat (2) @(negedge clk_in);
        run_refill(32'h0000_3000, 0, 1'b0, 32'h0000_3000, 32'h5958_5B5A, 2);
        run_refill(32'h0000_2000, 1, 1'b0, 32'h0000_2000, 32'h5958_5B5A, 0);
        repeat (2) @(negedge clk_in);
        run_refill(32'h0000_4000, 0, 1'b0, 32'h0000_4000, 32'h5958_5B5A, 1);
        repeat (2) @(negedge clk_in);
        run_refill(32'h0000_1006, 0, 1'b0, 32'h0000_1004, 32'h0000_0513, 3);
        repeat (2) @(negedge clk_in);
        run_refill(32'h0000_5000, 0, 1'b0, 32'h0000_5000, 32'h5958_5B5A, 4);
        repeat (2) @(negedge clk_in);
        nf = fills;
        run_refill(32'h0000_0000, 0, 1'b0, 32'h0000_0000, 32'h5958_5B5A, 5);
        @(negedge clk_in);
        miss_pc_in = 32'h0000_0004;
        #1;
        chk("guard", {31'b0, bus.mem_req_out}, 0);
        run_refill(32'h0000_0004, 0, 1'b0, 32'h0000_0004, 32'h5D5C_5F5E, 0);
        chk("b2b_fills", fills - nf, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
